baccarat_round_ctrl: RTL and testbench
======================================

Name: baccarat_round_ctrl

Overview:
Parametrised successor to the single-round baccarat dealing controller. It sequences a full punto banco round (four initial cards, player third-card rule, full banker third-card table) over a request/acknowledge handshake to the card source. It drives the per-slot card-load strobes and the win lights, holds the result for a programmable time, and keeps saturating win/tie tallies. It supports single-shot and auto-repeat play and sits between the deck/card-register datapath and the display logic.

Parameters:
HOLD_CYCLES, 8, slow_clock cycles the result is held before the round ends (>=1).
TALLY_W, 8, width of each win/tie tally counter.
CNT_W, 4, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
slow_clock  in  1  clock, rising edge
resetb  in  1  asynchronous active-low reset
start  in  1  level; begin a round when IDLE
auto_mode  in  1  1 = restart automatically after HOLD; 0 = return to IDLE
card_ack  in  1  card source has a card this cycle; completes the request
pscore  in  4  player hand score 0..9, from the card registers
dscore  in  4  banker hand score 0..9, from the card registers
pcard3  in  4  player third card value 0..9
card_req  out  1  requesting a card from the source
load_pcard1, load_pcard2, load_pcard3  out  1 each  one-cycle load strobes for the player slots
load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle load strobes for the banker slots
player_win_light  out  1  player won (both lights set = tie)
dealer_win_light  out  1  banker won
round_done  out  1  one-cycle pulse on the cycle HOLD expires
busy  out  1  high in every state except IDLE
player_wins, dealer_wins, ties  out  TALLY_W each  saturating tallies

Behaviour:
- Reset (async, resetb=0): state IDLE. Every output is 0, all tallies are 0, and the hold counter is 0.
- States: IDLE, P1, D1, P2, D2, CHK, P3, BDEC, D3, RES, HOLD.
- IDLE: when start=1, go to P1 on the next edge.
- Deal states (P1, D1, P2, D2, P3, D3):
  - card_req=1 throughout the state.
  - When card_ack=1, the matching load strobe is 1 in that same cycle (combinational from state and card_ack), and the state advances on that edge.
  - With card_ack=0 the state waits indefinitely and all strobes stay 0.
  - At most one strobe is ever high in a cycle.
- Deal order: P1 -> D1 -> P2 -> D2 -> CHK.
- Scores are valid in the cycle after a load strobe. CHK and BDEC each last one cycle and sample pscore, dscore and pcard3 then.
- CHK transitions:
  - pscore>=8 or dscore>=8 (natural) -> RES.
  - else pscore<=5 -> P3.
  - else (player stands on 6/7): dscore<=5 -> D3, otherwise -> RES.
- P3 -> BDEC once acknowledged.
- BDEC, banker draws (-> D3) when:
  - dscore 0..2: always.
  - dscore 3: pcard3 != 8.
  - dscore 4: pcard3 in 2..7.
  - dscore 5: pcard3 in 4..7.
  - dscore 6: pcard3 in 6..7.
  - dscore 7: never.
  - Otherwise -> RES.
- D3 -> RES once acknowledged.
- RES (one cycle): compares pscore and dscore.
  - Registers the lights on the exit edge: player>banker sets player light; banker>player sets dealer light; equal sets both.
  - Increments exactly one tally on the same edge. A tally at 2^TALLY_W-1 holds its value.
  - Then -> HOLD.
- HOLD:
  - Lights stay registered; the counter counts HOLD_CYCLES cycles.
  - On the last cycle, round_done=1.
  - Next state: auto_mode=1 -> P1 (lights cleared on that edge); auto_mode=0 -> IDLE (lights stay on until the next start is accepted).
  - auto_mode is sampled only on that final HOLD cycle.
- start is ignored outside IDLE. Holding start=1 in IDLE with auto_mode=0 begins a new round on each return to IDLE.
- When a round starts from IDLE, the lights clear on the IDLE->P1 edge.
- Reset mid-round returns to IDLE immediately: strobes and card_req drop asynchronously, and the tallies are cleared.
- Any unused state encoding -> IDLE on the next edge.
- The controller does not latch or check score values. Out-of-range scores (>9) are treated per the comparisons above, and only unsigned compares are used.

Test Plan:
- Natural: start=1, card_ack always 1, pscore=9, dscore=3 at CHK -> no P3/D3 strobes, player_win_light=1, dealer light 0, player_wins=1, round_done pulses HOLD_CYCLES cycles after RES.
- Banker rule: pscore=4 at CHK, pcard3=8, dscore=3 at BDEC -> load_pcard3 pulses, load_dcard3 never pulses; repeat with pcard3=7 -> load_dcard3 pulses once.
- Player stands: pscore=7, dscore=5 -> load_dcard3 pulses without load_pcard3; with dscore=6 and pscore=6 at RES -> both lights on, ties=1.
- Stall: hold card_ack=0 for 5 cycles in D1 -> card_req stays 1, no strobes, state unchanged; ack on cycle 6 -> load_dcard1 for exactly 1 cycle.
- Auto and saturation: TALLY_W=2, auto_mode=1, force banker wins for 5 rounds -> dealer_wins reads 1,2,3,3,3 and rounds restart without start.
- Reset mid-round: drop resetb during P3 with card_ack=1 -> all outputs 0 asynchronously, tallies 0, IDLE after release.

Source files
------------

// File: rtl/baccarat_round_ctrl_if.sv
// Card-source handshake, score inputs, and display/tally outputs of the baccarat round controller.
// The master modport is the controller side; the slave modport is the deck/display environment.
interface baccarat_round_ctrl_if #(
    parameter int TALLY_W = 8
);
    logic               start;
    logic               auto_mode;
    logic               card_ack;
    logic [3:0]         pscore;
    logic [3:0]         dscore;
    logic [3:0]         pcard3;
    logic               card_req;
    logic               load_pcard1;
    logic               load_pcard2;
    logic               load_pcard3;
    logic               load_dcard1;
    logic               load_dcard2;
    logic               load_dcard3;
    logic               player_win_light;
    logic               dealer_win_light;
    logic               round_done;
    logic               busy;
    logic [TALLY_W-1:0] player_wins;
    logic [TALLY_W-1:0] dealer_wins;
    logic [TALLY_W-1:0] ties;

    modport master (
        input  start, auto_mode, card_ack, pscore, dscore, pcard3,
        output card_req, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
               player_win_light, dealer_win_light, round_done, busy,
               player_wins, dealer_wins, ties
    );

    modport slave (
        output start, auto_mode, card_ack, pscore, dscore, pcard3,
        input  card_req, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
               player_win_light, dealer_win_light, round_done, busy,
               player_wins, dealer_wins, ties
    );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Punto banco round sequencer: deals cards over req/ack, applies third-card rules, holds result, keeps tallies.
// Load strobes are combinational on card_ack; a deal state waits indefinitely while card_ack is low.
module baccarat_round_ctrl #(
    parameter int HOLD_CYCLES = 8,
    parameter int TALLY_W     = 8,
    parameter int CNT_W       = 4
) (
    input logic                   slow_clock,
    input logic                   resetb,
    baccarat_round_ctrl_if.master rnd
);

    typedef enum logic [3:0] {
        IDLE = 4'd0, P1, D1, P2, D2, CHK, P3, BDEC, D3, RES, HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               plight_q, plight_d;
    logic               dlight_q, dlight_d;
    logic [TALLY_W-1:0] pwin_q, pwin_d;
    logic [TALLY_W-1:0] dwin_q, dwin_d;
    logic [TALLY_W-1:0] tie_q, tie_d;
    logic               card_req_c;
    logic               round_done_c;
    logic [5:0]         load_c;
    logic               hold_last;
    logic               banker_draws;

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (&v) ? v : v + TALLY_W'(1);
    endfunction

    assign hold_last = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));

    // Banker third-card table, indexed by banker score and the player's third card
    always_comb begin
        banker_draws = 1'b0;
        case (rnd.dscore)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (rnd.pcard3 != 4'd8);
            4'd4:             banker_draws = (rnd.pcard3 >= 4'd2) && (rnd.pcard3 <= 4'd7);
            4'd5:             banker_draws = (rnd.pcard3 >= 4'd4) && (rnd.pcard3 <= 4'd7);
            4'd6:             banker_draws = (rnd.pcard3 >= 4'd6) && (rnd.pcard3 <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        plight_d     = plight_q;
        dlight_d     = dlight_q;
        pwin_d       = pwin_q;
        dwin_d       = dwin_q;
        tie_d        = tie_q;
        card_req_c   = 1'b0;
        round_done_c = 1'b0;
        load_c       = 6'b0;
        case (state_q)
            IDLE: begin
                if (rnd.start) begin
                    state_d  = P1;
                    plight_d = 1'b0;
                    dlight_d = 1'b0;
                end
            end
            P1: begin
                card_req_c = 1'b1;
                if (rnd.card_ack) begin
                    load_c[0] = 1'b1;
                    state_d   = D1;
                end
            end
            D1: begin
                card_req_c = 1'b1;
                if (rnd.card_ack) begin
                    load_c[1] = 1'b1;
                    state_d   = P2;
                end
            end
            P2: begin
                card_req_c = 1'b1;
                if (rnd.card_ack) begin
                    load_c[2] = 1'b1;
                    state_d   = D2;
                end
            end
            D2: begin
                card_req_c = 1'b1;
                if (rnd.card_ack) begin
                    load_c[3] = 1'b1;
                    state_d   = CHK;
                end
            end
            CHK: begin
                if (rnd.pscore >= 4'd8 || rnd.dscore >= 4'd8) state_d = RES;
                else if (rnd.pscore <= 4'd5)                   state_d = P3;
                else if (rnd.dscore <= 4'd5)                   state_d = D3;
                else                                           state_d = RES;
            end
            P3: begin
                card_req_c = 1'b1;
                if (rnd.card_ack) begin
                    load_c[4] = 1'b1;
                    state_d   = BDEC;
                end
            end
            BDEC: state_d = banker_draws ? D3 : RES;
            D3: begin
                card_req_c = 1'b1;
                if (rnd.card_ack) begin
                    load_c[5] = 1'b1;
                    state_d   = RES;
                end
            end
            RES: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
                if (rnd.pscore > rnd.dscore) begin
                    plight_d = 1'b1;
                    dlight_d = 1'b0;
                    pwin_d   = sat_inc(pwin_q);
                end else if (rnd.dscore > rnd.pscore) begin
                    plight_d = 1'b0;
                    dlight_d = 1'b1;
                    dwin_d   = sat_inc(dwin_q);
                end else begin
                    plight_d = 1'b1;
                    dlight_d = 1'b1;
                    tie_d    = sat_inc(tie_q);
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (hold_last) begin
                    round_done_c = 1'b1;
                    if (rnd.auto_mode) begin
                        state_d  = P1;
                        plight_d = 1'b0;
                        dlight_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            plight_q   <= 1'b0;
            dlight_q   <= 1'b0;
            pwin_q     <= '0;
            dwin_q     <= '0;
            tie_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            plight_q   <= plight_d;
            dlight_q   <= dlight_d;
            pwin_q     <= pwin_d;
            dwin_q     <= dwin_d;
            tie_q      <= tie_d;
        end
    end

    assign rnd.card_req         = card_req_c;
    assign rnd.load_pcard1      = load_c[0];
    assign rnd.load_dcard1      = load_c[1];
    assign rnd.load_pcard2      = load_c[2];
    assign rnd.load_dcard2      = load_c[3];
    assign rnd.load_pcard3      = load_c[4];
    assign rnd.load_dcard3      = load_c[5];
    assign rnd.round_done       = round_done_c;
    assign rnd.busy             = (state_q != IDLE);
    assign rnd.player_win_light = plight_q;
    assign rnd.dealer_win_light = dlight_q;
    assign rnd.player_wins      = pwin_q;
    assign rnd.dealer_wins      = dwin_q;
    assign rnd.ties             = tie_q;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Self-checking bench for baccarat_round_ctrl: vector table, hand-written corner sequences, random rounds vs a round-level model.
// Uses a short hold and 2-bit tallies so saturation is reachable quickly.
module tb_baccarat_round_ctrl;
    localparam int HOLD = 3;
    localparam int TW   = 2;
    localparam int CW   = 2;
    localparam int TMAX = (1 << TW) - 1;

    logic slow_clock = 1'b0;
    logic resetb     = 1'b0;

    baccarat_round_ctrl_if #(.TALLY_W(TW)) bus ();

    baccarat_round_ctrl #(
        .HOLD_CYCLES(HOLD),
        .TALLY_W    (TW),
        .CNT_W      (CW)
    ) dut (
        .slow_clock(slow_clock),
        .resetb    (resetb),
        .rnd       (bus)
    );

    always #5 slow_clock = ~slow_clock;

    int tests = 0;
    int fails = 0;
    int strobe_err = 0;
    int pw = 0, dw = 0, tw = 0;

    typedef struct {
        int p;
        int d;
        int c3;
        int exp_seq;
        int exp_lights;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.load_dcard3, bus.load_pcard3, bus.load_dcard2,
                bus.load_pcard2, bus.load_dcard1, bus.load_pcard1};
    endfunction

    // Round-level reference: which cards get dealt (as nibbles 1..6 in deal order) and who wins
    function automatic void ref_round(input int p, input int d, input int c3,
                                      output int seq, output int lights);
        logic [15:0] draw_mask [16];
        bit p3, d3;
        for (int k = 0; k < 16; k++) draw_mask[k] = 16'h0000;
        draw_mask[0] = 16'hFFFF;
        draw_mask[1] = 16'hFFFF;
        draw_mask[2] = 16'hFFFF;
        draw_mask[3] = 16'hFEFF;
        draw_mask[4] = 16'h00FC;
        draw_mask[5] = 16'h00F0;
        draw_mask[6] = 16'h00C0;
        p3 = 0;
        d3 = 0;
        if (p < 8 && d < 8) begin
            if (p <= 5) begin
                p3 = 1;
                d3 = draw_mask[d][c3];
            end else begin
                d3 = (d <= 5);
            end
        end
        seq = 'h1234;
        if (p3) seq = (seq << 4) | 5;
        if (d3) seq = (seq << 4) | 6;
        lights = (p > d) ? 2 : (d > p) ? 1 : 3;
    endfunction

    function automatic int sat(input int v);
        return (v >= TMAX) ? TMAX : v + 1;
    endfunction

    // Drives one round until round_done; records deal order and the cycles from the last strobe to round_done
    task automatic run_round(input bit do_start, input int ack_pct,
                             output int seq, output int gap, output int last_idx,
                             output logic [1:0] lights, output bit timed_out);
        logic [5:0] s;
        int last;
        int idx;
        seq = 0;
        gap = -1;
        last = 0;
        last_idx = -1;
        lights = 2'b00;
        timed_out = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge slow_clock);
            bus.start    = do_start && (i == 0);
            bus.card_ack = ($urandom_range(0, 99) < ack_pct);
            #1;
            s = strobes();
            if ($countones(s) > 1) strobe_err++;
            if (s != 0 && (!bus.card_ack || !bus.card_req)) strobe_err++;
            if (s != 0) begin
                idx = 0;
                for (int k = 0; k < 6; k++) if (s[k]) idx = k;
                if (idx == 0) chk("lights_clear_at_p1", {bus.player_win_light, bus.dealer_win_light}, 2'b00);
                seq = (seq << 4) | (idx + 1);
                last = i;
                last_idx = idx;
            end
            if (bus.round_done) begin
                gap = i - last;
                lights = {bus.player_win_light, bus.dealer_win_light};
                timed_out = 0;
                break;
            end
        end
        bus.start = 1'b0;
        bus.card_ack = 1'b0;
    endtask

    task automatic check_round(input string tag, input int p, input int d, input int c3,
                               input bit do_start, input int ack_pct);
        int seq, gap, lidx, eseq, elights;
        logic [1:0] lights;
        bit to;
        bus.pscore = 4'(p);
        bus.dscore = 4'(d);
        bus.pcard3 = 4'(c3);
        ref_round(p, d, c3, eseq, elights);
        run_round(do_start, ack_pct, seq, gap, lidx, lights, to);
        if (to) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no round_done within budget", tag);
            return;
        end
        chk({tag, "_seq"}, seq, eseq);
        chk({tag, "_lights"}, lights, elights);
        chk({tag, "_gap"}, gap, (lidx == 5) ? HOLD + 1 : HOLD + 2);
        if (elights == 2) pw = sat(pw);
        else if (elights == 1) dw = sat(dw);
        else tw = sat(tw);
        chk({tag, "_pwins"}, bus.player_wins, pw);
        chk({tag, "_dwins"}, bus.dealer_wins, dw);
        chk({tag, "_ties"}, bus.ties, tw);
    endtask

    initial begin
        logic [1:0] held;
        bit found;

        vecs[0]  = '{9,  3, 0, 'h1234,   2};
        vecs[1]  = '{4,  3, 8, 'h12345,  2};
        vecs[2]  = '{4,  3, 7, 'h123456, 2};
        vecs[3]  = '{7,  5, 0, 'h12346,  2};
        vecs[4]  = '{6,  6, 0, 'h1234,   3};
        vecs[5]  = '{2,  7, 5, 'h12345,  1};
        vecs[6]  = '{0,  8, 0, 'h1234,   1};
        vecs[7]  = '{5,  6, 6, 'h123456, 1};
        vecs[8]  = '{5,  6, 5, 'h12345,  1};
        vecs[9]  = '{3,  4, 1, 'h12345,  1};
        vecs[10] = '{3,  4, 2, 'h123456, 1};
        vecs[11] = '{1,  5, 3, 'h12345,  1};
        vecs[12] = '{12, 0, 0, 'h1234,   2};

        bus.start = 0; bus.auto_mode = 0; bus.card_ack = 0;
        bus.pscore = 0; bus.dscore = 0; bus.pcard3 = 0;

        #12;
        chk("rst_outputs", {bus.card_req, strobes(), bus.round_done, bus.busy,
                            bus.player_win_light, bus.dealer_win_light}, 0);
        chk("rst_tallies", {bus.player_wins, bus.dealer_wins, bus.ties}, 0);
        @(negedge slow_clock);
        resetb = 1'b1;

        // Table: independent rounds, card source always ready; lights must persist in IDLE
        foreach (vecs[v]) begin
            int eseq, el;
            ref_round(vecs[v].p, vecs[v].d, vecs[v].c3, eseq, el);
            chk("model_vs_table", eseq, vecs[v].exp_seq);
            check_round($sformatf("vec%0d", v), vecs[v].p, vecs[v].d, vecs[v].c3, 1, 100);
            held = {bus.player_win_light, bus.dealer_win_light};
            @(negedge slow_clock);
            #1;
            chk("idle_busy", bus.busy, 0);
            chk("idle_lights_hold", {bus.player_win_light, bus.dealer_win_light}, vecs[v].exp_lights);
        end

        // Stall five cycles in D1, then acknowledge
        bus.pscore = 4'd9; bus.dscore = 4'd3; bus.pcard3 = 4'd0;
        @(negedge slow_clock); bus.start = 1; bus.card_ack = 0;
        @(negedge slow_clock); bus.start = 0; bus.card_ack = 1; #1;
        chk("stall_p1_strobe", strobes(), 6'b000001);
        for (int i = 0; i < 5; i++) begin
            @(negedge slow_clock); bus.card_ack = 0; #1;
            chk("stall_req", bus.card_req, 1);
            chk("stall_nostrobe", strobes(), 0);
        end
        @(negedge slow_clock); bus.card_ack = 1; #1;
        chk("stall_d1_strobe", strobes(), 6'b000010);
        @(negedge slow_clock); bus.card_ack = 0; #1;
        chk("stall_d1_once", strobes(), 0);
        begin
            int seq, gap, lidx;
            logic [1:0] lt;
            bit to;
            run_round(0, 100, seq, gap, lidx, lt, to);
            chk("stall_rest_seq", seq, 'h34);
            chk("stall_lights", lt, 2'b10);
            chk("stall_gap", gap, HOLD + 2);
            pw = sat(pw);
            chk("stall_pwins", bus.player_wins, pw);
        end

        // Random rounds with a sluggish card source
        for (int r = 0; r < 40; r++) begin
            check_round($sformatf("rnd%0d", r), $urandom_range(0, 11), $urandom_range(0, 11),
                        $urandom_range(0, 15), 1, 60);
        end

        // Auto-repeat with banker wins from a cleared tally
        @(negedge slow_clock); resetb = 0;
        #1;
        chk("rst2_tallies", {bus.player_wins, bus.dealer_wins, bus.ties}, 0);
        @(negedge slow_clock); resetb = 1;
        pw = 0; dw = 0; tw = 0;
        bus.auto_mode = 1;
        for (int r = 0; r < 5; r++) begin
            check_round($sformatf("auto%0d", r), 1, 9, 0, r == 0, 100);
        end
        @(negedge slow_clock); #1;
        chk("auto_restart_busy", bus.busy, 1);
        bus.auto_mode = 0;

        // Reset asserted while the player's third card is being acknowledged
        bus.pscore = 4'd4; bus.dscore = 4'd3; bus.pcard3 = 4'd8;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge slow_clock); bus.card_ack = 1; #1;
            if (bus.load_pcard3) found = 1;
        end
        chk("reach_p3", found, 1);
        chk("pre_rst_dwins", bus.dealer_wins, TMAX);
        resetb = 0;
        #1;
        chk("midrst_outputs", {bus.card_req, strobes(), bus.round_done, bus.busy,
                               bus.player_win_light, bus.dealer_win_light}, 0);
        chk("midrst_tallies", {bus.player_wins, bus.dealer_wins, bus.ties}, 0);
        @(negedge slow_clock); bus.card_ack = 0; resetb = 1;
        @(negedge slow_clock); #1;
        chk("post_rst_idle", {bus.busy, bus.card_req}, 0);
        pw = 0; dw = 0; tw = 0;
        check_round("post_rst", 9, 3, 0, 1, 100);

        chk("strobe_errors", strobe_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
